// File: rtl/cont_mem_mc_pkg.sv
// Shared types and helpers for the multi-class continuous item/class memory.
// Holds the operation and FSM encodings, derived-width helpers and the counter update rule.
package cont_mem_mc_pkg;

  typedef enum logic [1:0] {
    MODE_TRAIN    = 2'b00,
    MODE_QUERY    = 2'b01,
    MODE_OVERRIDE = 2'b10,
    MODE_CLEAR    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int calc_chunks(input int dims, input int par);
    return dims / par;
  endfunction

  function automatic int calc_class_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_dist_w(input int dims);
    return $clog2(dims + 1);
  endfunction

  // New counter value for one dimension; saturates instead of wrapping.
  function automatic int sat_update(input int cnt, input logic b, input mode_e m, input int cnt_w);
    int hi;
    int lo;
    int res;
    hi  = (1 << (cnt_w - 1)) - 1;
    lo  = -(1 << (cnt_w - 1));
    res = cnt;
    case (m)
      MODE_TRAIN: begin
        if (b && (cnt < hi))       res = cnt + 1;
        else if (!b && (cnt > lo)) res = cnt - 1;
      end
      MODE_OVERRIDE: res = b ? 1 : -1;
      MODE_CLEAR:    res = 0;
      default:       res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cont_mem_mc_if.sv
// Command/result bundle for cont_mem_mc: the requester drives the master side,
// the memory implements the slave side.
interface cont_mem_mc_if
  import cont_mem_mc_pkg::*;
#(
  parameter int DIMENSIONS  = 6,
  parameter int NUM_CLASSES = 2
);
  localparam int CLASS_W = calc_class_w(NUM_CLASSES);
  localparam int DIST_W  = calc_dist_w(DIMENSIONS);

  // Handshake: start is taken only while busy=0 (one accepted operation per start
  // cycle in IDLE); mode/label/hv_in are captured on that edge and ignored afterwards.
  // done pulses for exactly one cycle per accepted operation, with err alongside it.
  logic                  start;
  mode_e                 mode;
  logic [CLASS_W-1:0]    label;
  logic [DIMENSIONS-1:0] hv_in;
  logic [CLASS_W-1:0]    rd_class;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [CLASS_W-1:0]    pred_class;
  logic [DIST_W-1:0]     pred_dist;
  logic [DIMENSIONS-1:0] rd_hv;
  state_e                dbg_state;

  modport master (
    output start, mode, label, hv_in, rd_class,
    input  busy, done, err, pred_class, pred_dist, rd_hv, dbg_state
  );

  modport slave (
    input  start, mode, label, hv_in, rd_class,
    output busy, done, err, pred_class, pred_dist, rd_hv, dbg_state
  );

endinterface

// File: rtl/cont_mem_mc_hamming_chunk.sv
// Combinational popcount of the XOR of two PAR_BITS-wide slices.
module hamming_chunk #(
  parameter int PAR_BITS = 2,
  parameter int DIST_W   = 3
) (
  input  logic [PAR_BITS-1:0] a,
  input  logic [PAR_BITS-1:0] b,
  output logic [DIST_W-1:0]   count
);

  logic [PAR_BITS-1:0] diff;

  always_comb begin
    diff  = a ^ b;
    count = '0;
    for (int i = 0; i < PAR_BITS; i++) begin
      count = count + DIST_W'(diff[i]);
    end
  end

endmodule

// File: rtl/cont_mem_mc.sv
// Multi-class HDC class memory: saturating per-dimension counters with train,
// override, clear and Hamming-argmin query, PAR_BITS dimensions per cycle.
module cont_mem_mc
  import cont_mem_mc_pkg::*;
#(
  parameter int DIMENSIONS  = 6,
  parameter int PAR_BITS    = 2,
  parameter int NUM_CLASSES = 2,
  parameter int CNT_WIDTH   = 3
) (
  input logic          clk,
  input logic          rst,
  cont_mem_mc_if.slave bus
);

  localparam int CHUNKS  = calc_chunks(DIMENSIONS, PAR_BITS);
  localparam int CLASS_W = calc_class_w(NUM_CLASSES);
  localparam int DIST_W  = calc_dist_w(DIMENSIONS);
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  state_e                state_q, state_d;
  mode_e                 mode_q;
  logic [CLASS_W-1:0]    label_q;
  logic                  label_ok_q;
  logic [DIMENSIONS-1:0] hv_q;
  logic [CHUNK_W-1:0]    chunk_q;

  logic signed [CNT_WIDTH-1:0] cnt_q [NUM_CLASSES][DIMENSIONS];
  logic [DIMENSIONS-1:0]       sign_w [NUM_CLASSES];

  logic [PAR_BITS-1:0] hv_chunk;
  logic [PAR_BITS-1:0] sign_chunk [NUM_CLASSES];
  logic [DIST_W-1:0]   pc_w  [NUM_CLASSES];
  logic [DIST_W-1:0]   acc_q [NUM_CLASSES];
  logic [DIST_W-1:0]   acc_d [NUM_CLASSES];

  logic [CLASS_W-1:0] best_class, pred_class_q;
  logic [DIST_W-1:0]  best_dist, pred_dist_q;

  logic start_ok, last_chunk;
  logic busy_w, done_w, err_w;
  logic [DIMENSIONS-1:0] rd_hv_w;

  assign start_ok   = (state_q == ST_IDLE) && bus.start;
  assign last_chunk = (chunk_q == CHUNK_W'(CHUNKS - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_w = (state_q == ST_RUN) || (state_q == ST_DONE);
    done_w = (state_q == ST_DONE);
    err_w  = (state_q == ST_DONE) && (mode_q != MODE_QUERY) && !label_ok_q;
  end

  // Class sign view: strictly positive counters read as 1, zero reads as 0.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int d = 0; d < DIMENSIONS; d++) begin
        sign_w[c][d] = !cnt_q[c][d][CNT_WIDTH-1] && (cnt_q[c][d] != '0);
      end
    end
  end

  always_comb begin
    hv_chunk = hv_q[int'(chunk_q)*PAR_BITS +: PAR_BITS];
    for (int c = 0; c < NUM_CLASSES; c++) begin
      sign_chunk[c] = sign_w[c][int'(chunk_q)*PAR_BITS +: PAR_BITS];
    end
  end

  for (genvar gc = 0; gc < NUM_CLASSES; gc++) begin : g_ham
    hamming_chunk #(
      .PAR_BITS (PAR_BITS),
      .DIST_W   (DIST_W)
    ) u_ham (
      .a     (hv_chunk),
      .b     (sign_chunk[gc]),
      .count (pc_w[gc])
    );
  end

  // Argmin over the accumulators including the current chunk; strict < keeps the lowest index on ties.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      acc_d[c] = acc_q[c] + pc_w[c];
    end
    best_class = '0;
    best_dist  = acc_d[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (acc_d[c] < best_dist) begin
        best_dist  = acc_d[c];
        best_class = CLASS_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_TRAIN;
      label_q      <= '0;
      label_ok_q   <= 1'b0;
      hv_q         <= '0;
      chunk_q      <= '0;
      pred_class_q <= '0;
      pred_dist_q  <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
        for (int d = 0; d < DIMENSIONS; d++) begin
          cnt_q[c][d] <= '0;
        end
      end
    end else if (start_ok) begin
      mode_q     <= bus.mode;
      label_q    <= bus.label;
      label_ok_q <= (int'(bus.label) < NUM_CLASSES);
      hv_q       <= bus.hv_in;
      chunk_q    <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else if (state_q == ST_RUN) begin
      chunk_q <= chunk_q + 1'b1;
      if (mode_q == MODE_QUERY) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          acc_q[c] <= acc_d[c];
        end
        if (last_chunk) begin
          pred_class_q <= best_class;
          pred_dist_q  <= best_dist;
        end
      end else if (label_ok_q) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          for (int d = 0; d < DIMENSIONS; d++) begin
            if ((label_q == CLASS_W'(c)) && ((d / PAR_BITS) == int'(chunk_q))) begin
              cnt_q[c][d] <= CNT_WIDTH'(sat_update(int'(cnt_q[c][d]), hv_q[d], mode_q, CNT_WIDTH));
            end
          end
        end
      end
    end
  end

  // Out-of-range rd_class matches no class and reads as zero.
  always_comb begin
    rd_hv_w = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (bus.rd_class == CLASS_W'(c)) rd_hv_w = sign_w[c];
    end
  end

  assign bus.busy       = busy_w;
  assign bus.done       = done_w;
  assign bus.err        = err_w;
  assign bus.pred_class = pred_class_q;
  assign bus.pred_dist  = pred_dist_q;
  assign bus.rd_hv      = rd_hv_w;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_cont_mem_mc.sv
// Directed bench for cont_mem_mc: a 2-class instance driven from a vector table
// plus hand sequences, and a 3-class instance for out-of-range labels.
module tb_cont_mem_mc;
  import cont_mem_mc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cont_mem_mc_if #(.DIMENSIONS(6), .NUM_CLASSES(2)) if2 ();
  cont_mem_mc_if #(.DIMENSIONS(6), .NUM_CLASSES(3)) if3 ();

  cont_mem_mc #(.DIMENSIONS(6), .PAR_BITS(2), .NUM_CLASSES(2), .CNT_WIDTH(3)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  cont_mem_mc #(.DIMENSIONS(6), .PAR_BITS(2), .NUM_CLASSES(3), .CNT_WIDTH(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       do_rst;
    mode_e      mode;
    logic [1:0] label;
    logic [5:0] hv;
    logic [1:0] rd_cls;
    logic [5:0] exp_hv;
    logic       chk_pred;
    logic [1:0] exp_pc;
    logic [2:0] exp_pd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input mode_e m, input logic [1:0] l, input logic [5:0] hv,
                         input logic [1:0] rc, input logic [5:0] ehv, input logic cp,
                         input logic [1:0] epc, input logic [2:0] epd);
    vec_t v;
    v.do_rst = r;  v.mode = m;  v.label = l;  v.hv = hv;  v.rd_cls = rc;
    v.exp_hv = ehv; v.chk_pred = cp; v.exp_pc = epc; v.exp_pd = epd;
    vecs.push_back(v);
  endtask

  // ---------------- clock / reset ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic read_hv(input int sel, input logic [1:0] cls, output logic [5:0] v);
    if (sel == 2) if2.rd_class = cls[0];
    else          if3.rd_class = cls;
    #1;
    v = (sel == 2) ? if2.rd_hv : if3.rd_hv;
  endtask

  // Latency counts the start cycle as 1 and the cycle showing done as the last.
  task automatic run_op(input int sel, input mode_e m, input logic [1:0] lbl, input logic [5:0] hv,
                        output int lat, output logic err_seen);
    logic found;
    logic d;
    @(negedge clk);
    if (sel == 2) begin
      if2.start = 1'b1; if2.mode = m; if2.label = lbl[0]; if2.hv_in = hv;
    end else begin
      if3.start = 1'b1; if3.mode = m; if3.label = lbl;    if3.hv_in = hv;
    end
    @(posedge clk);
    #1;
    if2.start = 1'b0; if3.start = 1'b0;
    if2.hv_in = ~hv;  if3.hv_in = ~hv;
    lat = 1;
    err_seen = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      d = (sel == 2) ? if2.done : if3.done;
      if (d) begin
        found = 1'b1;
        err_seen = (sel == 2) ? if2.err : if3.err;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    check("done_seen", 32'(found), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        e;
    logic [5:0]  v;
    int          dones;

    rst = 1'b1;
    if2.start = 1'b0; if2.mode = MODE_TRAIN; if2.label = '0; if2.hv_in = '0; if2.rd_class = '0;
    if3.start = 1'b0; if3.mode = MODE_TRAIN; if3.label = '0; if3.hv_in = '0; if3.rd_class = '0;

    // Test 1: override and query
    add_vec(1'b0, MODE_OVERRIDE, 2'd0, 6'b000001, 2'd0, 6'b000001, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_OVERRIDE, 2'd1, 6'b111110, 2'd1, 6'b111110, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_QUERY,    2'd0, 6'b000011, 2'd0, 6'b000001, 1'b1, 2'd0, 3'd1);
    // Test 2: bundling
    add_vec(1'b1, MODE_TRAIN, 2'd0, 6'b100001, 2'd0, 6'b100001, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b110000, 2'd0, 6'b100000, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b110001, 2'd0, 6'b110001, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd1, 6'b110111, 2'd1, 6'b110111, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd1, 6'b011110, 2'd1, 6'b010110, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd1, 6'b111111, 2'd1, 6'b111111, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_QUERY, 2'd0, 6'b111111, 2'd1, 6'b111111, 1'b1, 2'd1, 3'd0);
    // Test 3: saturation at +3, then down to 0, -1, back up
    add_vec(1'b1, MODE_TRAIN, 2'd0, 6'b111111, 2'd0, 6'b111111, 1'b0, 2'd0, 3'd0);
    for (int i = 0; i < 4; i++)
      add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b111111, 2'd0, 6'b111111, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b000000, 2'd0, 6'b111111, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b000000, 2'd0, 6'b111111, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b000000, 2'd0, 6'b000000, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b000000, 2'd0, 6'b000000, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b111111, 2'd0, 6'b000000, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_TRAIN, 2'd0, 6'b111111, 2'd0, 6'b111111, 1'b0, 2'd0, 3'd0);
    // Test 4: tie and clear (pred must hold across CLEAR)
    add_vec(1'b1, MODE_OVERRIDE, 2'd0, 6'b101010, 2'd0, 6'b101010, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_OVERRIDE, 2'd1, 6'b101010, 2'd1, 6'b101010, 1'b0, 2'd0, 3'd0);
    add_vec(1'b0, MODE_QUERY,    2'd0, 6'b000000, 2'd0, 6'b101010, 1'b1, 2'd0, 3'd3);
    add_vec(1'b0, MODE_CLEAR,    2'd1, 6'b111111, 2'd1, 6'b000000, 1'b1, 2'd0, 3'd3);
    add_vec(1'b0, MODE_QUERY,    2'd0, 6'b000000, 2'd1, 6'b000000, 1'b1, 2'd1, 3'd0);

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_busy",  32'(if2.busy), 32'd0);
    check("rst_done",  32'(if2.done), 32'd0);
    check("rst_err",   32'(if2.err),  32'd0);
    check("rst_pc",    32'(if2.pred_class), 32'd0);
    check("rst_pd",    32'(if2.pred_dist),  32'd0);
    read_hv(2, 2'd0, v); check("rst_hv0", 32'(v), 32'd0);
    read_hv(2, 2'd1, v); check("rst_hv1", 32'(v), 32'd0);

    // Table-driven vectors on the 2-class instance
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      run_op(2, vecs[i].mode, vecs[i].label, vecs[i].hv, lat, e);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_err", i), 32'(e), 32'd0);
      read_hv(2, vecs[i].rd_cls, v);
      check($sformatf("vec%0d_hv", i), 32'(v), 32'(vecs[i].exp_hv));
      if (vecs[i].chk_pred) begin
        check($sformatf("vec%0d_pc", i), 32'(if2.pred_class), 32'(vecs[i].exp_pc));
        check($sformatf("vec%0d_pd", i), 32'(if2.pred_dist),  32'(vecs[i].exp_pd));
      end
    end

    // start held during RUN with different fields: ignored, one done only.
    // Class0 counters are +1/-1 from 101010; training 111111 gives +2/0 -> 101010.
    @(negedge clk);
    if2.start = 1'b1; if2.mode = MODE_TRAIN; if2.label = 1'b0; if2.hv_in = 6'b111111;
    @(posedge clk);
    #1;
    if2.mode = MODE_OVERRIDE; if2.label = 1'b1; if2.hv_in = 6'b000111;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if2.done) dones++;
      if (i == 2) if2.start = 1'b0;
    end
    check("ign_dones", 32'(dones), 32'd1);
    read_hv(2, 2'd0, v); check("ign_hv0", 32'(v), 32'b101010);
    read_hv(2, 2'd1, v); check("ign_hv1", 32'(v), 32'b000000);

    // Out-of-range labels on the 3-class instance
    run_op(3, MODE_OVERRIDE, 2'd2, 6'b111000, lat, e);
    check("inv_ovr_err", 32'(e), 32'd0);
    run_op(3, MODE_TRAIN, 2'd3, 6'b111111, lat, e);
    check("inv_trn_lat", 32'(lat), 32'd4);
    check("inv_trn_err", 32'(e), 32'd1);
    run_op(3, MODE_CLEAR, 2'd3, 6'b000000, lat, e);
    check("inv_clr_err", 32'(e), 32'd1);
    read_hv(3, 2'd0, v); check("inv_hv0", 32'(v), 32'b000000);
    read_hv(3, 2'd1, v); check("inv_hv1", 32'(v), 32'b000000);
    read_hv(3, 2'd2, v); check("inv_hv2", 32'(v), 32'b111000);
    read_hv(3, 2'd3, v); check("inv_hv3", 32'(v), 32'b000000);

    // Query to get non-zero pred: class0 101010 dist 6, class1 000000 dist 3.
    run_op(2, MODE_QUERY, 2'd0, 6'b010101, lat, e);
    check("pre_rst_pc", 32'(if2.pred_class), 32'd1);
    check("pre_rst_pd", 32'(if2.pred_dist),  32'd3);

    // Reset during RUN chunk 1 of a TRAIN
    @(negedge clk);
    if2.start = 1'b1; if2.mode = MODE_TRAIN; if2.label = 1'b0; if2.hv_in = 6'b111111;
    @(posedge clk);
    #1 if2.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if2.done) dones++;
    end
    check("mid_rst_dones", 32'(dones), 32'd0);
    check("mid_rst_busy",  32'(if2.busy), 32'd0);
    check("mid_rst_pc",    32'(if2.pred_class), 32'd0);
    check("mid_rst_pd",    32'(if2.pred_dist),  32'd0);
    read_hv(2, 2'd0, v); check("mid_rst_hv0", 32'(v), 32'd0);
    read_hv(2, 2'd1, v); check("mid_rst_hv1", 32'(v), 32'd0);
    read_hv(3, 2'd2, v); check("mid_rst_hv3_2", 32'(v), 32'd0);
    run_op(2, MODE_OVERRIDE, 2'd1, 6'b010101, lat, e);
    check("post_rst_lat", 32'(lat), 32'd4);
    read_hv(2, 2'd1, v); check("post_rst_hv1", 32'(v), 32'b010101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
